// File: rtl/reg_file_fwd_sb.sv
// Register file with per-register pending scoreboard and
// priority forwarding on registered read addresses.
module reg_file_fwd_sb #(
   parameter int XLEN  = 32,
   parameter int NREAD = 2,
   parameter int NFWD  = 2,
   parameter int AW    = 5,
   parameter int PW    = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  FLUSH,
   input  logic                  STALL,
   input  logic                  MEM_WAIT,
   input  logic [NREAD*AW-1:0]   RADDR,
   output logic [NREAD-1:0]      RVALID,
   output logic [NREAD*XLEN-1:0] RDATA,
   input  logic                  ISSUE_EN,
   input  logic [AW-1:0]         ISSUE_ADDR,
   output logic                  ISSUE_FULL,
   input  logic                  WB_EN,
   input  logic [AW-1:0]         WB_ADDR,
   input  logic [XLEN-1:0]       WB_DATA,
   input  logic [NFWD-1:0]       FWD_EN,
   input  logic [NFWD-1:0]       FWD_READY,
   input  logic [NFWD*AW-1:0]    FWD_ADDR,
   input  logic [NFWD*XLEN-1:0]  FWD_DATA
);

   localparam int DEPTH = 1 << AW;
   localparam logic [PW-1:0] PMAX = '1;

   logic [XLEN-1:0] regs_q  [DEPTH];
   logic [PW-1:0]   pend_q  [DEPTH];
   logic [PW-1:0]   pend_d  [DEPTH];
   logic [AW-1:0]   raddr_q [NREAD];
   logic [AW-1:0]   raddr_d [NREAD];

   logic             wb_ok;
   logic             issue_ok;
   logic [DEPTH-1:0] inc;
   logic [DEPTH-1:0] dec;

   assign wb_ok    = WB_EN && (WB_ADDR != '0);
   assign issue_ok = ISSUE_EN && (ISSUE_ADDR != '0) &&
                     !FLUSH && !STALL && !MEM_WAIT &&
                     (pend_q[ISSUE_ADDR] != PMAX);

   assign ISSUE_FULL = (pend_q[ISSUE_ADDR] == PMAX);

   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : g_sb
         assign inc[g] = issue_ok && (ISSUE_ADDR == AW'(g));
         assign dec[g] = wb_ok && (WB_ADDR == AW'(g)) &&
                         (pend_q[g] != '0);
      end
   endgenerate

   // Simultaneous reserve and release of one register cancel out.
   always_comb begin
      for (int r = 0; r < DEPTH; r++) begin
         pend_d[r] = pend_q[r];
         if (FLUSH)
            pend_d[r] = '0;
         else if (inc[r] && !dec[r])
            pend_d[r] = pend_q[r] + 1'b1;
         else if (dec[r] && !inc[r])
            pend_d[r] = pend_q[r] - 1'b1;
      end
   end

   always_comb begin
      for (int p = 0; p < NREAD; p++) begin
         raddr_d[p] = raddr_q[p];
         if (FLUSH)
            raddr_d[p] = '0;
         else if (!STALL && !MEM_WAIT)
            raddr_d[p] = RADDR[p*AW +: AW];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int r = 0; r < DEPTH; r++) begin
            regs_q[r] <= '0;
            pend_q[r] <= '0;
         end
         for (int p = 0; p < NREAD; p++)
            raddr_q[p] <= '0;
      end else begin
         if (wb_ok)
            regs_q[WB_ADDR] <= WB_DATA;
         for (int r = 0; r < DEPTH; r++)
            pend_q[r] <= pend_d[r];
         for (int p = 0; p < NREAD; p++)
            raddr_q[p] <= raddr_d[p];
      end
   end

   genvar q;
   generate
      for (q = 0; q < NREAD; q++) begin : g_rd
         logic [AW-1:0]   ra;
         logic            fhit;
         logic            frdy;
         logic [XLEN-1:0] fdat;
         logic [XLEN-1:0] rd;
         logic            rv;

         assign ra = raddr_q[q];

         // Scan downward so the youngest matching channel wins.
         always_comb begin
            fhit = 1'b0;
            frdy = 1'b0;
            fdat = '0;
            for (int c = NFWD - 1; c >= 0; c--) begin
               if (FWD_EN[c] && (FWD_ADDR[c*AW +: AW] == ra)) begin
                  fhit = 1'b1;
                  frdy = FWD_READY[c];
                  fdat = FWD_DATA[c*XLEN +: XLEN];
               end
            end
         end

         always_comb begin
            rd = regs_q[ra];
            rv = 1'b1;
            if (ra == '0) begin
               rd = '0;
               rv = 1'b1;
            end else begin
               if (fhit)
                  rd = fdat;
               else if (WB_EN && (WB_ADDR == ra))
                  rd = WB_DATA;
               if (pend_q[ra] != '0)
                  rv = fhit && frdy;
            end
         end

         assign RDATA[q*XLEN +: XLEN] = rd;
         assign RVALID[q]             = rv;
      end
   endgenerate

endmodule

// File: tb/tb_reg_file_fwd_sb.sv
// Directed bench for reg_file_fwd_sb: scoreboard,
// forwarding priority, flush, stall and x0 handling.
module tb_reg_file_fwd_sb;

   logic        CLK;
   logic        RST;
   logic        FLUSH;
   logic        STALL;
   logic        MEM_WAIT;
   logic [9:0]  RADDR;
   logic [1:0]  RVALID;
   logic [63:0] RDATA;
   logic        ISSUE_EN;
   logic [4:0]  ISSUE_ADDR;
   logic        ISSUE_FULL;
   logic        WB_EN;
   logic [4:0]  WB_ADDR;
   logic [31:0] WB_DATA;
   logic [1:0]  FWD_EN;
   logic [1:0]  FWD_READY;
   logic [9:0]  FWD_ADDR;
   logic [63:0] FWD_DATA;

   int checks;
   int failures;

   reg_file_fwd_sb dut (
      .CLK        (CLK),
      .RST        (RST),
      .FLUSH      (FLUSH),
      .STALL      (STALL),
      .MEM_WAIT   (MEM_WAIT),
      .RADDR      (RADDR),
      .RVALID     (RVALID),
      .RDATA      (RDATA),
      .ISSUE_EN   (ISSUE_EN),
      .ISSUE_ADDR (ISSUE_ADDR),
      .ISSUE_FULL (ISSUE_FULL),
      .WB_EN      (WB_EN),
      .WB_ADDR    (WB_ADDR),
      .WB_DATA    (WB_DATA),
      .FWD_EN     (FWD_EN),
      .FWD_READY  (FWD_READY),
      .FWD_ADDR   (FWD_ADDR),
      .FWD_DATA   (FWD_DATA)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      @(negedge CLK);
      #1;
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      RST        = 1'b1;
      FLUSH      = 1'b0;
      STALL      = 1'b0;
      MEM_WAIT   = 1'b0;
      RADDR      = '0;
      ISSUE_EN   = 1'b0;
      ISSUE_ADDR = '0;
      WB_EN      = 1'b0;
      WB_ADDR    = '0;
      WB_DATA    = '0;
      FWD_EN     = '0;
      FWD_READY  = '0;
      FWD_ADDR   = '0;
      FWD_DATA   = '0;
      cyc();
      cyc();
      RST = 1'b0;
      cyc();

      chk("rst_rvalid", RVALID, 2'b11);
      chk("rst_rdata", RDATA, 64'h0);
      chk("rst_full", ISSUE_FULL, 1'b0);

      // writeback then read x5
      WB_EN   = 1'b1;
      WB_ADDR = 5'd5;
      WB_DATA = 32'hDEADBEEF;
      cyc();
      WB_EN      = 1'b0;
      RADDR[4:0] = 5'd5;
      cyc();
      chk("x5_data", RDATA[31:0], 32'hDEADBEEF);
      chk("x5_valid", RVALID[0], 1'b1);
      chk("x0_port1", RDATA[63:32], 32'h0);

      // writeback bypass to a live read
      WB_EN   = 1'b1;
      WB_ADDR = 5'd5;
      WB_DATA = 32'h1234;
      #1;
      chk("wb_bypass", RDATA[31:0], 32'h1234);
      cyc();
      WB_EN = 1'b0;
      #1;
      chk("x5_new", RDATA[31:0], 32'h1234);

      // reserve x7, read without forward
      ISSUE_EN   = 1'b1;
      ISSUE_ADDR = 5'd7;
      cyc();
      ISSUE_EN   = 1'b0;
      RADDR[4:0] = 5'd7;
      cyc();
      chk("x7_pend_valid", RVALID[0], 1'b0);
      chk("x7_pend_data", RDATA[31:0], 32'h0);

      FWD_EN           = 2'b10;
      FWD_READY        = 2'b10;
      FWD_ADDR[9:5]    = 5'd7;
      FWD_DATA[63:32]  = 32'h11;
      #1;
      chk("fwd1_valid", RVALID[0], 1'b1);
      chk("fwd1_data", RDATA[31:0], 32'h11);

      // both channels hit, youngest wins
      FWD_EN          = 2'b11;
      FWD_READY       = 2'b10;
      FWD_ADDR        = {5'd7, 5'd7};
      FWD_DATA        = {32'hBB, 32'hAA};
      #1;
      chk("prio_data", RDATA[31:0], 32'hAA);
      chk("prio_valid", RVALID[0], 1'b0);
      FWD_EN = '0;

      // release x7
      WB_EN   = 1'b1;
      WB_ADDR = 5'd7;
      WB_DATA = 32'h77;
      cyc();
      WB_EN = 1'b0;
      #1;
      chk("x7_rel_valid", RVALID[0], 1'b1);
      chk("x7_rel_data", RDATA[31:0], 32'h77);

      // saturate x3
      ISSUE_EN   = 1'b1;
      ISSUE_ADDR = 5'd3;
      #1;
      chk("x3_full0", ISSUE_FULL, 1'b0);
      cyc();
      cyc();
      cyc();
      chk("x3_full3", ISSUE_FULL, 1'b1);
      cyc();
      ISSUE_EN = 1'b0;
      #1;
      chk("x3_full4", ISSUE_FULL, 1'b1);
      RADDR[4:0] = 5'd3;
      cyc();
      chk("x3_v3", RVALID[0], 1'b0);
      WB_EN   = 1'b1;
      WB_ADDR = 5'd3;
      WB_DATA = 32'h33;
      cyc();
      chk("x3_full2", ISSUE_FULL, 1'b0);
      chk("x3_v2", RVALID[0], 1'b0);
      cyc();
      chk("x3_v1", RVALID[0], 1'b0);
      cyc();
      WB_EN = 1'b0;
      #1;
      chk("x3_v0", RVALID[0], 1'b1);
      chk("x3_data", RDATA[31:0], 32'h33);

      // same-cycle issue and release of x4
      ISSUE_EN   = 1'b1;
      ISSUE_ADDR = 5'd4;
      cyc();
      WB_EN   = 1'b1;
      WB_ADDR = 5'd4;
      WB_DATA = 32'h44;
      cyc();
      WB_EN      = 1'b0;
      ISSUE_EN   = 1'b0;
      RADDR[4:0] = 5'd4;
      cyc();
      chk("x4_cnt1_valid", RVALID[0], 1'b0);
      ISSUE_EN = 1'b1;
      cyc();
      ISSUE_EN = 1'b0;
      #1;
      chk("x4_cnt2", ISSUE_FULL, 1'b0);
      ISSUE_EN = 1'b1;
      cyc();
      ISSUE_EN = 1'b0;
      #1;
      chk("x4_cnt3", ISSUE_FULL, 1'b1);

      // flush with a concurrent writeback to x9
      FLUSH   = 1'b1;
      WB_EN   = 1'b1;
      WB_ADDR = 5'd9;
      WB_DATA = 32'h99;
      cyc();
      FLUSH = 1'b0;
      WB_EN = 1'b0;
      #1;
      chk("fl_full", ISSUE_FULL, 1'b0);
      chk("fl_rdata", RDATA, 64'h0);
      chk("fl_rvalid", RVALID, 2'b11);
      RADDR[4:0] = 5'd4;
      cyc();
      chk("fl_x4_valid", RVALID[0], 1'b1);
      chk("fl_x4_data", RDATA[31:0], 32'h44);
      RADDR[4:0] = 5'd9;
      cyc();
      chk("fl_x9_data", RDATA[31:0], 32'h99);

      // writes to x0 are dropped
      WB_EN      = 1'b1;
      WB_ADDR    = 5'd0;
      WB_DATA    = 32'hFFFF;
      RADDR[4:0] = 5'd0;
      cyc();
      WB_EN = 1'b0;
      #1;
      chk("x0_data", RDATA[31:0], 32'h0);
      chk("x0_valid", RVALID[0], 1'b1);

      // stall and mem_wait hold the read address
      RADDR[4:0] = 5'd5;
      cyc();
      chk("pre_stall", RDATA[31:0], 32'h1234);
      STALL      = 1'b1;
      RADDR[4:0] = 5'd9;
      cyc();
      cyc();
      cyc();
      chk("stall_hold", RDATA[31:0], 32'h1234);
      STALL    = 1'b0;
      MEM_WAIT = 1'b1;
      cyc();
      chk("mw_hold", RDATA[31:0], 32'h1234);
      MEM_WAIT = 1'b0;
      RADDR    = {5'd7, 5'd9};
      cyc();
      chk("resume_p0", RDATA[31:0], 32'h99);
      chk("resume_p1", RDATA[63:32], 32'h77);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
